decode_forward_stage: RTL
=========================

# decode_forward_stage

Decode-to-execute boundary block; it applies the forwarding selects and load-use stall produced by the hazard unit. Each cycle it resolves the A, B and predicate operands from the register file or a forwarding source. It evaluates the instruction predicate and registers the result into the ID/EX pipeline register. On a stall or flush it inserts a bubble and drives the PC and IF/ID hold and flush controls.

## Interface
Parameters:
- DW, 32, datapath width
- CTRL_W, 8, decoded control bundle width. Bit 0 is RegWrite, bit 1 is MemRd, bit 2 is MemWr; the remaining bits pass through.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- BusA_RF, BusB_RF, BusP_RF  in  DW each  register-file reads for Rs, Rt, Rp
- ALU_EX  in  DW  EX-stage ALU result (combinational)
- Res_MEM  in  DW  MEM-stage result
- BusW_WB  in  DW  WB write-back bus
- FWA, FWB, FWP  in  2 each  forwarding selects: 00 RF, 01 EX, 10 MEM, 11 WB
- Stall  in  1  load-use stall request
- Flush  in  1  control-flow redirect; kills the instruction in ID
- ctrl_ID  in  CTRL_W  decoded control bundle
- pred_en_ID  in  1  instruction is predicated on Rp
- Imm_ID  in  DW  extended immediate
- RW_ID  in  5  destination register
- PC_ID  in  DW  instruction PC
- A_EX, B_EX, Imm_EX, PC_EX  out  DW each  registered operands
- ctrl_EX  out  CTRL_W  registered control bundle
- RW_EX  out  5  registered destination register
- valid_EX  out  1  the EX slot holds a live instruction
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Operand mux (combinational), applied independently to A, B and P:
  - 00 selects the *_RF input.
  - 01 selects ALU_EX.
  - 10 selects Res_MEM.
  - 11 selects BusW_WB.
- Predicate:
  - pred_false = pred_en_ID & (P_fwd == 0).
  - A predicated-false instruction still enters EX with its operands, but with ctrl_EX = 0, RW_EX = 0 and valid_EX = 0. This squashes all side effects.
- Per-cycle load decision, in priority order:
  1. Flush: load a bubble (ctrl_EX = 0, RW_EX = 0, valid_EX = 0). Drive ifid_flush = 1, pc_en = 1, ifid_en = 1.
  2. Stall: load a bubble. Drive pc_en = 0, ifid_en = 0, ifid_flush = 0. IF/ID holds, so the stalled instruction re-decodes next cycle with updated FW selects.
  3. Otherwise: load A/B from the mux and load Imm, PC, RW and ctrl from ID, subject to the predicate squash. Set valid_EX = !pred_false. Drive pc_en = 1, ifid_en = 1, ifid_flush = 0.
- Bubble data: on a bubble, the data registers (A_EX, B_EX, Imm_EX, PC_EX) keep their previous values. Only ctrl_EX, RW_EX and valid_EX are cleared.
- Flush and Stall together: Flush wins, and the stall is discarded because the dependent instruction is killed.
- The block keeps no state across instructions other than the pipeline register and stall_cnt.

## Timing
- Operand mux, predicate logic, pc_en, ifid_en and ifid_flush are combinational from same-cycle inputs.
- ID/EX outputs update on the rising clk edge that follows the decision: 1-cycle latency from ID to EX.
- Zero added latency for any forwarding path. A 01 select uses the same-cycle ALU_EX.
- A single Stall cycle produces exactly one bubble. N consecutive Stall cycles produce N bubbles and hold the PC for N cycles.
- Reset (rst_n low, asynchronous, at any time including mid-stall):
  - All registered outputs go to 0 immediately. This includes valid_EX = 0, ctrl_EX = 0 and stall_cnt = 0.
  - The combinational outputs follow their inputs.
  - The first rising edge after rst_n deasserts performs a normal load.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cnt increments on each rising edge where Stall = 1 and Flush = 0.
  - It saturates at 32'hFFFFFFFF and does not wrap.
  - It is cleared only by reset.
- STALL_PERF_CNT_EN undefined: stall_cnt is tied to 32'd0 and no counter register is built.

## Test plan
- Forward select sweep: BusA_RF = 1, ALU_EX = 2, Res_MEM = 3, BusW_WB = 4; step FWA through 00/01/10/11 with no stall -> A_EX = 1, 2, 3, 4 on successive cycles, valid_EX = 1.
- Load-use: Stall = 1 for one cycle with ctrl_ID = 8'h01, RW_ID = 5 -> that cycle pc_en = 0 and ifid_en = 0; next edge ctrl_EX = 0, RW_EX = 0, valid_EX = 0. The following cycle, with Stall = 0, ctrl_EX = 8'h01, RW_EX = 5.
- Predicate: pred_en_ID = 1, FWP = 01, ALU_EX = 0, ctrl_ID = 8'h05 -> ctrl_EX = 0, valid_EX = 0. Repeat with ALU_EX = 7 -> ctrl_EX = 8'h05, valid_EX = 1.
- Flush with Stall: Flush = 1 and Stall = 1 together -> ifid_flush = 1, pc_en = 1, bubble in EX, stall_cnt unchanged.
- Counter: with STALL_PERF_CNT_EN, hold Stall = 1 for 3 cycles -> stall_cnt = 3. Force it to 32'hFFFFFFFE and stall for 2 cycles -> stall_cnt = 32'hFFFFFFFF. Without the macro, stall_cnt = 0 throughout.
- Async reset: assert rst_n = 0 between edges while valid_EX = 1 and stall_cnt = 9 -> valid_EX, ctrl_EX and stall_cnt go to 0 before the next edge.

Source files
------------

// File: rtl/decode_forward_stage.sv
// ID/EX boundary: forwarded operand resolution, predicate squash, stall/flush bubbles.
// Optional saturating stall counter built only when STALL_PERF_CNT_EN is defined.
module decode_forward_stage #(
    parameter int DW     = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     BusA_RF,
    input  logic [DW-1:0]     BusB_RF,
    input  logic [DW-1:0]     BusP_RF,
    input  logic [DW-1:0]     ALU_EX,
    input  logic [DW-1:0]     Res_MEM,
    input  logic [DW-1:0]     BusW_WB,
    input  logic [1:0]        FWA,
    input  logic [1:0]        FWB,
    input  logic [1:0]        FWP,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              pred_en_ID,
    input  logic [DW-1:0]     Imm_ID,
    input  logic [4:0]        RW_ID,
    input  logic [DW-1:0]     PC_ID,
    output logic [DW-1:0]     A_EX,
    output logic [DW-1:0]     B_EX,
    output logic [DW-1:0]     Imm_EX,
    output logic [DW-1:0]     PC_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [4:0]        RW_EX,
    output logic              valid_EX,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic [31:0]       stall_cnt
);

    function automatic logic [DW-1:0] fwd_sel(
        input logic [1:0]    sel,
        input logic [DW-1:0] rf,
        input logic [DW-1:0] ex,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] wb
    );
        logic [DW-1:0] res;
        case (sel)
            2'b00:   res = rf;
            2'b01:   res = ex;
            2'b10:   res = mem;
            2'b11:   res = wb;
            default: res = rf;
        endcase
        return res;
    endfunction

    logic [DW-1:0]     a_fwd_s;
    logic [DW-1:0]     b_fwd_s;
    logic [DW-1:0]     p_fwd_s;
    logic              pred_false_s;
    logic              bubble_s;
    logic              pc_en_s;
    logic              ifid_en_s;
    logic              ifid_flush_s;
    logic [DW-1:0]     a_r;
    logic [DW-1:0]     b_r;
    logic [DW-1:0]     imm_r;
    logic [DW-1:0]     pc_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [4:0]        rw_r;
    logic              valid_r;

    // Operand forwarding and predicate evaluation
    always_comb begin
        a_fwd_s      = fwd_sel(FWA, BusA_RF, ALU_EX, Res_MEM, BusW_WB);
        b_fwd_s      = fwd_sel(FWB, BusB_RF, ALU_EX, Res_MEM, BusW_WB);
        p_fwd_s      = fwd_sel(FWP, BusP_RF, ALU_EX, Res_MEM, BusW_WB);
        pred_false_s = pred_en_ID & (p_fwd_s == {DW{1'b0}});
    end

    // Load decision: a flush kills any concurrent stall since the dependent instruction dies
    always_comb begin
        pc_en_s      = 1'b1;
        ifid_en_s    = 1'b1;
        ifid_flush_s = 1'b0;
        bubble_s     = 1'b0;
        if (Flush) begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b1;
            bubble_s     = 1'b1;
        end else if (Stall) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            ifid_flush_s = 1'b0;
            bubble_s     = 1'b1;
        end else begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b0;
            bubble_s     = 1'b0;
        end
    end

    // ID/EX pipeline register; bubbles clear only control, data keeps its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {DW{1'b0}};
            b_r     <= {DW{1'b0}};
            imm_r   <= {DW{1'b0}};
            pc_r    <= {DW{1'b0}};
            ctrl_r  <= {CTRL_W{1'b0}};
            rw_r    <= 5'd0;
            valid_r <= 1'b0;
        end else if (bubble_s) begin
            ctrl_r  <= {CTRL_W{1'b0}};
            rw_r    <= 5'd0;
            valid_r <= 1'b0;
        end else begin
            a_r     <= a_fwd_s;
            b_r     <= b_fwd_s;
            imm_r   <= Imm_ID;
            pc_r    <= PC_ID;
            ctrl_r  <= pred_false_s ? {CTRL_W{1'b0}} : ctrl_ID;
            rw_r    <= pred_false_s ? 5'd0 : RW_ID;
            valid_r <= ~pred_false_s;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles actually lost to stalls (flushed stalls excluded)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (Stall && !Flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

    assign A_EX       = a_r;
    assign B_EX       = b_r;
    assign Imm_EX     = imm_r;
    assign PC_EX      = pc_r;
    assign ctrl_EX    = ctrl_r;
    assign RW_EX      = rw_r;
    assign valid_EX   = valid_r;
    assign pc_en      = pc_en_s;
    assign ifid_en    = ifid_en_s;
    assign ifid_flush = ifid_flush_s;

endmodule
